serial_flow_unit: RTL and testbench
===================================

# serial_flow_unit

Parameterised multi-lane serial arithmetic engine. Each lane receives two LSB-first serial bit streams and either adds them or compares them magnitude-wise. Word-end overflow (add mode) or equality (compare mode) is flagged per lane. It extends the single-lane 2-input serial FSM used in the benchmark set to N lanes, a configurable word length, a runtime mode select and a bit-valid qualifier. It sits between the serial line receivers and the status/monitor logic.

## Interface

Parameters:
- LANES, 2, number of independent serial lanes (≥1)
- WORD_LEN, 8, bits per serial word (≥2)
- CNT_W, $clog2(WORD_LEN), bit-counter width (derived, not overridden)

Ports:
- clock  in  1  single clock, rising edge
- nRESET_G  in  1  asynchronous active-low reset
- SCLR  in  1  synchronous clear, highest priority after reset
- EN  in  1  bit-valid; LINE1/LINE2 sampled only when high
- MODE  in  1  0 = add, 1 = compare; sampled on first bit of a word
- LINE1  in  LANES  serial operand A per lane, LSB first
- LINE2  in  LANES  serial operand B per lane, LSB first
- OUTP_REG  out  LANES  add: registered sum bit; compare: running A>B
- OVERFLW_REG  out  LANES  word-end flag. Add: carry out. Compare: A==B.
- WORD_DONE  out  1  one-cycle pulse on last bit of word
- BIT_CNT  out  CNT_W  index of next bit to be sampled

## Operation

- Shared FSM with two states:
  - IDLE: BIT_CNT=0, no word open.
  - ACTIVE: word in progress.
- FSM transitions:
  - IDLE→ACTIVE on EN. This first bit is processed immediately, and MODE is latched into mode_q.
  - ACTIVE→IDLE on EN with BIT_CNT==WORD_LEN-1.
  - EN low holds the current state.
- Per lane, add mode (a=LINE1[i], b=LINE2[i], c=carry):
  - sum = a^b^c
  - carry ← (a&b)|(c&(a^b))
  - carry is taken as 0 on bit 0.
- Per lane, compare mode:
  - gt ← (a&~b) | (~(a^b) & gt), with gt=0 on bit 0.
  - eq ← eq & ~(a^b), with eq=1 on bit 0.
  - OUTP_REG shows the updated gt.
- Last bit (EN, BIT_CNT==WORD_LEN-1):
  - WORD_DONE=1.
  - OVERFLW_REG[i] = final carry (add) or final eq (compare).
  - Lane state reinitialised; BIT_CNT wraps to 0.
- MODE changes mid-word are ignored until the next word start.
- EN low:
  - OUTP_REG holds.
  - WORD_DONE and OVERFLW_REG are 0.
  - Counter and lane state hold; a gap of any length is legal.
- SCLR:
  - Counter, FSM, carry, gt cleared; eq set to 1.
  - All outputs 0 next cycle.
  - SCLR overrides a coincident EN, including an EN on the last bit.
- Lanes are fully independent; only BIT_CNT, FSM and mode_q are shared.

## Timing

- Reset values: OUTP_REG=0, OVERFLW_REG=0, WORD_DONE=0, BIT_CNT=0, FSM=IDLE, carry=0, gt=0, eq=1, mode_q=0.
- Reset assertion mid-word aborts the word immediately (asynchronous). No WORD_DONE is produced for the aborted word.
- Latency is 1 cycle: a bit sampled at edge k appears on OUTP_REG after edge k.
- WORD_DONE and OVERFLW_REG are asserted after the edge that samples the last bit, for exactly one cycle.
- Back-to-back words with EN held high: WORD_DONE pulses every WORD_LEN cycles, and the next word's bit 0 is sampled on the cycle after the last bit, with no bubble.
- All outputs are registered; no combinational input-to-output path.

## Structure

- Package serial_flow_pkg:
  - enum fsm_t {IDLE, ACTIVE}
  - enum mode_t {MODE_ADD=0, MODE_CMP=1}
  - localparam helper for CNT_W
- Sub-module serial_flow_lane (instantiated LANES times via generate):
  - Inputs: a, b, first, last, en, clr, mode_q.
  - Holds carry/gt/eq.
  - Drives outp and ovf registers.
- Top level holds the FSM, BIT_CNT, mode_q and WORD_DONE.

## Test plan

All scenarios use LANES=2, WORD_LEN=8 unless stated.

- Add overflow: lane0 A=0xFF, B=0x01, MODE=0, EN=1 for 8 cycles -> OUTP_REG[0] bits 0,0,0,0,0,0,0,0; on cycle 8 WORD_DONE=1 and OVERFLW_REG[0]=1. Lane1 A=0x12, B=0x34 -> serial 0x46, OVERFLW_REG[1]=0.
- Compare:
  - lane0 A=0x5A, B=0x5A, MODE=1 -> final OUTP_REG[0]=0, OVERFLW_REG[0]=1.
  - lane1 A=0x80, B=0x7F -> final OUTP_REG[1]=1, OVERFLW_REG[1]=0.
- EN gaps: 0x0F+0x01 with EN low for 3 cycles after bit 2 and 1 cycle after bit 6 -> sum 0x10, BIT_CNT frozen during gaps, a single WORD_DONE, OVERFLW_REG=0.
- Mode latching: MODE=1 at bit 0, toggled to 0 at bit 4, A=0x03, B=0x01 -> compare result persists, OVERFLW_REG=0 (unequal), final OUTP_REG=1.
- Back-to-back and clear: two add words with EN continuously high -> WORD_DONE at cycles 8 and 16. Then SCLR at bit 5 of a third word -> all outputs 0 and BIT_CNT=0 next cycle, and a following 0x01+0x01 word yields 0x02.
- Reset mid-word: nRESET_G low asynchronously at bit 3 -> all outputs 0 before the next edge; after release, a fresh 0xFF+0xFF word gives sum 0xFE and OVERFLW_REG=1. Repeat with LANES=4, WORD_LEN=5 for parameter coverage.

Source files
------------

// File: rtl/serial_flow_pkg.sv
// Shared types and sizing helpers for the multi-lane serial add/compare engine.
package serial_flow_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } fsm_t;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_CMP = 1'b1
   } mode_t;

   // Bit-counter width for a given word length; never narrower than one bit.
   function automatic int unsigned cnt_w_f(input int unsigned len);
      return (len <= 2) ? 1 : $clog2(len);
   endfunction

endpackage

// File: rtl/serial_flow_lane.sv
// One serial lane: LSB-first add (sum/carry) or magnitude compare (gt/eq).
module serial_flow_lane
   import serial_flow_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  a,
   input  logic  b,
   input  logic  first,
   input  logic  last,
   input  logic  en,
   input  logic  clr,
   input  mode_t mode_q,
   output logic  outp,
   output logic  ovf
);

   logic carry_q, gt_q, eq_q;
   logic carry_in_c, gt_in_c, eq_in_c;
   logic sum_c, carry_nx_c, gt_nx_c, eq_nx_c;

   // Bit 0 starts from the word's initial state regardless of leftover lane state.
   always_comb begin
      carry_in_c = first ? 1'b0 : carry_q;
      gt_in_c    = first ? 1'b0 : gt_q;
      eq_in_c    = first ? 1'b1 : eq_q;
      sum_c      = a ^ b ^ carry_in_c;
      carry_nx_c = (a & b) | (carry_in_c & (a ^ b));
      gt_nx_c    = (a & ~b) | (~(a ^ b) & gt_in_c);
      eq_nx_c    = eq_in_c & ~(a ^ b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b1;
         outp    <= 1'b0;
         ovf     <= 1'b0;
      end else if (clr) begin
         carry_q <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b1;
         outp    <= 1'b0;
         ovf     <= 1'b0;
      end else if (en) begin
         if (mode_q == MODE_CMP) begin
            outp <= gt_nx_c;
            gt_q <= last ? 1'b0 : gt_nx_c;
            eq_q <= last ? 1'b1 : eq_nx_c;
            ovf  <= last & eq_nx_c;
         end else begin
            outp    <= sum_c;
            carry_q <= ~last & carry_nx_c;
            ovf     <= last & carry_nx_c;
         end
      end else begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_flow_unit.sv
// Multi-lane serial arithmetic engine: shared word FSM/bit counter driving LANES lanes.
module serial_flow_unit
   import serial_flow_pkg::*;
#(
   parameter  int unsigned LANES    = 2,
   parameter  int unsigned WORD_LEN = 8,
   localparam int unsigned CNT_W    = cnt_w_f(WORD_LEN)
) (
   input  logic             clock,
   input  logic             nRESET_G,
   input  logic             SCLR,
   input  logic             EN,
   input  logic             MODE,
   input  logic [LANES-1:0] LINE1,
   input  logic [LANES-1:0] LINE2,
   output logic [LANES-1:0] OUTP_REG,
   output logic [LANES-1:0] OVERFLW_REG,
   output logic             WORD_DONE,
   output logic [CNT_W-1:0] BIT_CNT
);

   fsm_t             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_t            mode_q, mode_d;
   logic             word_done_d;
   logic             first_c, last_c;
   mode_t            mode_sel_c;

   always_ff @(posedge clock or negedge nRESET_G) begin
      if (!nRESET_G) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mode_q    <= MODE_ADD;
         WORD_DONE <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         WORD_DONE <= word_done_d;
      end
   end

   // Next-state: first bit latches MODE and is used live; last bit closes the word.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      word_done_d = 1'b0;
      first_c     = (state_q == IDLE);
      last_c      = (cnt_q == CNT_W'(WORD_LEN - 1));
      mode_sel_c  = first_c ? mode_t'(MODE) : mode_q;
      if (SCLR) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (EN) begin
         if (first_c) begin
            mode_d = mode_t'(MODE);
         end
         if (last_c) begin
            state_d     = IDLE;
            cnt_d       = '0;
            word_done_d = 1'b1;
         end else begin
            state_d = ACTIVE;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   assign BIT_CNT = cnt_q;

   for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
      serial_flow_lane u_lane (
         .clk    (clock),
         .rst_n  (nRESET_G),
         .a      (LINE1[i]),
         .b      (LINE2[i]),
         .first  (first_c),
         .last   (last_c),
         .en     (EN),
         .clr    (SCLR),
         .mode_q (mode_sel_c),
         .outp   (OUTP_REG[i]),
         .ovf    (OVERFLW_REG[i])
      );
   end

endmodule

// File: tb/tb_serial_flow_unit.sv
// Scoreboard bench for serial_flow_unit: 2x8 instance with a word-level model, plus a 4x5 instance.
module tb_serial_flow_unit;

   localparam int unsigned L  = 2;
   localparam int unsigned W  = 8;
   localparam int unsigned CW = 3;
   localparam int unsigned L2 = 4;
   localparam int unsigned W2 = 5;
   localparam int unsigned CW2 = 3;

   typedef struct packed {
      logic [L-1:0]  outp;
      logic [L-1:0]  ovf;
      logic          wd;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clock;
   logic          nRESET_G, SCLR, EN, MODE;
   logic [L-1:0]  LINE1, LINE2, OUTP_REG, OVERFLW_REG;
   logic          WORD_DONE;
   logic [CW-1:0] BIT_CNT;

   logic           rst2, sclr2, en2, mode2;
   logic [L2-1:0]  l1_2, l2_2, outp2, ovf2;
   logic           wd2;
   logic [CW2-1:0] cnt2;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Word-level reference: accumulated operand prefixes per lane
   int           m_cnt;
   logic         m_mode;
   int           m_a[L];
   int           m_b[L];
   logic [L-1:0] m_outp;

   logic [W-1:0] res[L];
   logic [L-1:0] last_ovf;
   int           wd_seen;

   serial_flow_unit #(.LANES(L), .WORD_LEN(W)) u_dut (
      .clock(clock), .nRESET_G(nRESET_G), .SCLR(SCLR), .EN(EN), .MODE(MODE),
      .LINE1(LINE1), .LINE2(LINE2), .OUTP_REG(OUTP_REG), .OVERFLW_REG(OVERFLW_REG),
      .WORD_DONE(WORD_DONE), .BIT_CNT(BIT_CNT)
   );

   serial_flow_unit #(.LANES(L2), .WORD_LEN(W2)) u_dut_p (
      .clock(clock), .nRESET_G(rst2), .SCLR(sclr2), .EN(en2), .MODE(mode2),
      .LINE1(l1_2), .LINE2(l2_2), .OUTP_REG(outp2), .OVERFLW_REG(ovf2),
      .WORD_DONE(wd2), .BIT_CNT(cnt2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Scoreboard: pop one expectation per edge that had stimulus queued
   always begin
      exp_t e;
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({OUTP_REG, OVERFLW_REG, WORD_DONE, BIT_CNT} !== e) begin
            failures++;
            $display("FAIL scoreboard t=%0t outp=%b/%b ovf=%b/%b wd=%b/%b cnt=%0d/%0d (got/exp)",
                     $time, OUTP_REG, e.outp, OVERFLW_REG, e.ovf, WORD_DONE, e.wd, BIT_CNT, e.cnt);
         end
      end
   end

   task automatic model_reset();
      m_cnt  = 0;
      m_mode = 1'b0;
      m_outp = '0;
      for (int i = 0; i < int'(L); i++) begin
         m_a[i] = 0;
         m_b[i] = 0;
      end
   endtask

   // Drive one cycle on the 2x8 instance and queue the reference result
   task automatic step(input logic e, input logic md, input logic sc,
                       input logic [L-1:0] a, input logic [L-1:0] b);
      exp_t x;
      @(negedge clock);
      EN = e; MODE = md; SCLR = sc; LINE1 = a; LINE2 = b;
      x.wd  = 1'b0;
      x.ovf = '0;
      if (sc) begin
         model_reset();
      end else if (e) begin
         if (m_cnt == 0) m_mode = md;
         for (int i = 0; i < int'(L); i++) begin
            m_a[i] = m_a[i] | (int'(a[i]) << m_cnt);
            m_b[i] = m_b[i] | (int'(b[i]) << m_cnt);
            m_outp[i] = m_mode ? (m_a[i] > m_b[i]) : 1'((m_a[i] + m_b[i]) >> m_cnt);
         end
         if (m_cnt == int'(W) - 1) begin
            x.wd = 1'b1;
            for (int i = 0; i < int'(L); i++) begin
               x.ovf[i] = m_mode ? (m_a[i] == m_b[i]) : 1'((m_a[i] + m_b[i]) >> W);
               m_a[i] = 0;
               m_b[i] = 0;
            end
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      x.outp = m_outp;
      x.cnt  = CW'(m_cnt);
      exp_q.push_back(x);
      @(posedge clock);
      #2;
   endtask

   task automatic run_word(input logic [W-1:0] a0, input logic [W-1:0] a1,
                           input logic [W-1:0] b0, input logic [W-1:0] b1,
                           input logic [W-1:0] modes);
      wd_seen = 0;
      for (int k = 0; k < int'(W); k++) begin
         step(1'b1, modes[k], 1'b0, {a1[k], a0[k]}, {b1[k], b0[k]});
         res[0][k] = OUTP_REG[0];
         res[1][k] = OUTP_REG[1];
         if (WORD_DONE) wd_seen++;
         last_ovf = OVERFLW_REG;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({OUTP_REG, OVERFLW_REG, WORD_DONE, BIT_CNT} !== '0) begin
         failures++;
         $display("FAIL reset_values got outp=%b ovf=%b wd=%b cnt=%0d want all 0",
                  OUTP_REG, OVERFLW_REG, WORD_DONE, BIT_CNT);
      end
      checks++;
      if ({outp2, ovf2, wd2, cnt2} !== '0) begin
         failures++;
         $display("FAIL reset_values_p got outp=%b ovf=%b wd=%b cnt=%0d want all 0",
                  outp2, ovf2, wd2, cnt2);
      end
   endtask

   task automatic test_add_overflow();
      run_word(8'hFF, 8'h12, 8'h01, 8'h34, 8'h00);
      checks++;
      if (res[0] !== 8'h00) begin failures++; $display("FAIL add_sum0 got %h want 00", res[0]); end
      checks++;
      if (res[1] !== 8'h46) begin failures++; $display("FAIL add_sum1 got %h want 46", res[1]); end
      checks++;
      if (last_ovf !== 2'b01) begin failures++; $display("FAIL add_ovf got %b want 01", last_ovf); end
      checks++;
      if (wd_seen != 1) begin failures++; $display("FAIL add_word_done got %0d want 1", wd_seen); end
   endtask

   task automatic test_compare();
      run_word(8'h5A, 8'h80, 8'h5A, 8'h7F, 8'hFF);
      checks++;
      if ({res[1][7], res[0][7]} !== 2'b10) begin
         failures++;
         $display("FAIL cmp_gt got %b want 10", {res[1][7], res[0][7]});
      end
      checks++;
      if (last_ovf !== 2'b01) begin failures++; $display("FAIL cmp_eq got %b want 01", last_ovf); end
   endtask

   task automatic test_en_gaps();
      wd_seen = 0;
      for (int k = 0; k < int'(W); k++) begin
         step(1'b1, 1'b0, 1'b0, {2{1'(8'h0F >> k)}}, {2{1'(8'h01 >> k)}});
         res[0][k] = OUTP_REG[0];
         res[1][k] = OUTP_REG[1];
         if (WORD_DONE) wd_seen++;
         last_ovf = OVERFLW_REG;
         if (k == 2 || k == 6) begin
            for (int g = 0; g < ((k == 2) ? 3 : 1); g++) begin
               step(1'b0, 1'($urandom_range(1)), 1'b0, 2'($urandom_range(3)), 2'($urandom_range(3)));
               if (WORD_DONE) wd_seen++;
               checks++;
               if (BIT_CNT !== CW'(k + 1)) begin
                  failures++;
                  $display("FAIL gap_cnt got %0d want %0d", BIT_CNT, k + 1);
               end
            end
         end
      end
      checks++;
      if (res[0] !== 8'h10 || res[1] !== 8'h10) begin
         failures++;
         $display("FAIL gap_sum got %h/%h want 10/10", res[0], res[1]);
      end
      checks++;
      if (wd_seen != 1 || last_ovf !== 2'b00) begin
         failures++;
         $display("FAIL gap_done got wd=%0d ovf=%b want wd=1 ovf=00", wd_seen, last_ovf);
      end
   endtask

   task automatic test_mode_latch();
      run_word(8'h03, 8'h03, 8'h01, 8'h01, 8'h0F);
      checks++;
      if (res[0] !== 8'hFE || res[1] !== 8'hFE) begin
         failures++;
         $display("FAIL latch_gt got %h/%h want FE/FE", res[0], res[1]);
      end
      checks++;
      if (last_ovf !== 2'b00) begin failures++; $display("FAIL latch_eq got %b want 00", last_ovf); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int done_at[$];
      logic [W-1:0] a0, a1, b0, b1;
      a0 = 8'h55; b0 = 8'h0F; a1 = 8'hC3; b1 = 8'h3C;
      cyc = 0;
      for (int n = 0; n < 2; n++) begin
         for (int k = 0; k < int'(W); k++) begin
            step(1'b1, 1'b0, 1'b0, {a1[k], a0[k]}, {b1[k], b0[k]});
            cyc++;
            res[0][k] = OUTP_REG[0];
            res[1][k] = OUTP_REG[1];
            if (WORD_DONE) done_at.push_back(cyc);
         end
      end
      checks++;
      if (done_at.size() != 2 || done_at[0] != 8 || done_at[1] != 16) begin
         failures++;
         $display("FAIL b2b_done got n=%0d want pulses at 8 and 16", done_at.size());
      end
      checks++;
      if (res[0] !== 8'h64 || res[1] !== 8'hFF) begin
         failures++;
         $display("FAIL b2b_sum got %h/%h want 64/FF", res[0], res[1]);
      end
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
      step(1'b1, 1'b0, 1'b1, 2'b11, 2'b11);
      checks++;
      if ({OUTP_REG, OVERFLW_REG, WORD_DONE, BIT_CNT} !== '0) begin
         failures++;
         $display("FAIL sclr got outp=%b ovf=%b wd=%b cnt=%0d want all 0",
                  OUTP_REG, OVERFLW_REG, WORD_DONE, BIT_CNT);
      end
      run_word(8'h01, 8'h01, 8'h01, 8'h01, 8'h00);
      checks++;
      if (res[0] !== 8'h02 || res[1] !== 8'h02 || last_ovf !== 2'b00) begin
         failures++;
         $display("FAIL post_sclr got %h/%h ovf=%b want 02/02 ovf=00", res[0], res[1], last_ovf);
      end
   endtask

   task automatic test_reset_mid_word();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
      @(negedge clock);
      EN = 1'b1; LINE1 = 2'b11; LINE2 = 2'b00;
      #2 nRESET_G = 1'b0;
      #1;
      checks++;
      if ({OUTP_REG, OVERFLW_REG, WORD_DONE, BIT_CNT} !== '0) begin
         failures++;
         $display("FAIL async_reset got outp=%b ovf=%b wd=%b cnt=%0d want all 0",
                  OUTP_REG, OVERFLW_REG, WORD_DONE, BIT_CNT);
      end
      model_reset();
      @(negedge clock);
      EN = 1'b0;
      nRESET_G = 1'b1;
      run_word(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
      checks++;
      if (res[0] !== 8'hFE || res[1] !== 8'hFE || last_ovf !== 2'b11 || wd_seen != 1) begin
         failures++;
         $display("FAIL reset_recover got %h/%h ovf=%b wd=%0d want FE/FE ovf=11 wd=1",
                  res[0], res[1], last_ovf, wd_seen);
      end
   endtask

   task automatic test_param();
      int s;
      s = 31 + 31;
      @(negedge clock);
      rst2 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         en2 = 1'b1; l1_2 = 4'hF; l2_2 = 4'h0;
         @(posedge clock);
         #2;
      end
      @(negedge clock);
      #2 rst2 = 1'b0;
      #1;
      checks++;
      if ({outp2, ovf2, wd2, cnt2} !== '0) begin
         failures++;
         $display("FAIL p_async_reset got outp=%b ovf=%b wd=%b cnt=%0d want all 0",
                  outp2, ovf2, wd2, cnt2);
      end
      @(negedge clock);
      en2 = 1'b0;
      rst2 = 1'b1;
      for (int k = 0; k < int'(W2); k++) begin
         @(negedge clock);
         en2 = 1'b1; l1_2 = 4'hF; l2_2 = 4'hF;
         @(posedge clock);
         #2;
         checks++;
         if (outp2 !== {L2{1'((s >> k) & 1)}}) begin
            failures++;
            $display("FAIL p_sum_bit%0d got %b want %b", k, outp2, {L2{1'((s >> k) & 1)}});
         end
      end
      checks++;
      if (wd2 !== 1'b1 || ovf2 !== 4'hF || cnt2 !== 3'd0) begin
         failures++;
         $display("FAIL p_word_end got wd=%b ovf=%b cnt=%0d want wd=1 ovf=1111 cnt=0", wd2, ovf2, cnt2);
      end
      @(negedge clock);
      en2 = 1'b0;
      @(posedge clock);
      #2;
      checks++;
      if (wd2 !== 1'b0 || ovf2 !== 4'h0) begin
         failures++;
         $display("FAIL p_pulse_len got wd=%b ovf=%b want 0/0000", wd2, ovf2);
      end
   endtask

   initial begin
      nRESET_G = 1'b0; SCLR = 1'b0; EN = 1'b0; MODE = 1'b0; LINE1 = '0; LINE2 = '0;
      rst2 = 1'b0; sclr2 = 1'b0; en2 = 1'b0; mode2 = 1'b0; l1_2 = '0; l2_2 = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #2;
      test_reset();
      @(negedge clock);
      nRESET_G = 1'b1;
      test_add_overflow();
      test_compare();
      test_en_gaps();
      test_mode_latch();
      test_back_to_back();
      test_reset_mid_word();
      test_param();
      repeat (2) @(posedge clock);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
